// File: rtl/scratch_mem_responder_pkg.sv
// Shared encodings for the scratch memory responder: client select, FSM state, word width.
package scratch_mem_responder_pkg;
   localparam int WORD_W = 128;

   typedef enum logic [1:0] {
      SEL_HIST = 2'd0,
      SEL_CDF  = 2'd1,
      SEL_DIV  = 2'd2,
      SEL_NONE = 2'd3
   } sel_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } state_e;
endpackage

// File: rtl/scratch_mem_array.sv
// DEPTH x WORD_W storage: one write port, two registered read ports with write-first bypass.
module scratch_mem_array
   import scratch_mem_responder_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int IW    = 6
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic [IW-1:0]     i_waddr,
   input  logic [WORD_W-1:0] i_wdata,
   input  logic [IW-1:0]     i_raddr0,
   input  logic [IW-1:0]     i_raddr1,
   input  logic              i_rzero0,
   input  logic              i_rzero1,
   output logic [WORD_W-1:0] o_rdata0,
   output logic [WORD_W-1:0] o_rdata1
);
   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [WORD_W-1:0] r_rdata0;
   logic [WORD_W-1:0] r_rdata1;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Read registers are reset; the array itself is not.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         if (i_rzero0)                          r_rdata0 <= '0;
         else if (i_we && i_waddr == i_raddr0)  r_rdata0 <= i_wdata;
         else                                   r_rdata0 <= r_mem[i_raddr0];
         if (i_rzero1)                          r_rdata1 <= '0;
         else if (i_we && i_waddr == i_raddr1)  r_rdata1 <= i_wdata;
         else                                   r_rdata1 <= r_mem[i_raddr1];
      end
   end

   assign o_rdata0 = r_rdata0;
   assign o_rdata1 = r_rdata1;
endmodule

// File: rtl/scratch_mem_responder.sv
// Client mux, zero-fill FSM and sticky range-error flag in front of the scratch array.
module scratch_mem_responder
   import scratch_mem_responder_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [1:0]        i_sel,
   input  logic              i_clear_req,
   input  logic [AW-1:0]     i_hist_raddr0,
   input  logic [AW-1:0]     i_hist_raddr1,
   input  logic              i_hist_we,
   input  logic [AW-1:0]     i_hist_waddr,
   input  logic [WORD_W-1:0] i_hist_wdata,
   input  logic [AW-1:0]     i_cdf_raddr0,
   input  logic [AW-1:0]     i_cdf_raddr1,
   input  logic              i_cdf_we,
   input  logic [AW-1:0]     i_cdf_waddr,
   input  logic [WORD_W-1:0] i_cdf_wdata,
   input  logic [AW-1:0]     i_div_raddr0,
   input  logic [AW-1:0]     i_div_raddr1,
   input  logic              i_div_we,
   input  logic [AW-1:0]     i_div_waddr,
   input  logic [WORD_W-1:0] i_div_wdata,
   output logic [WORD_W-1:0] o_hist_rdata0,
   output logic [WORD_W-1:0] o_hist_rdata1,
   output logic [WORD_W-1:0] o_cdf_rdata0,
   output logic [WORD_W-1:0] o_cdf_rdata1,
   output logic [WORD_W-1:0] o_div_rdata0,
   output logic [WORD_W-1:0] o_div_rdata1,
   output logic              o_busy,
   output logic              o_clear_done,
   output logic              o_addr_err
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_e            r_state, w_next;
   logic [IW-1:0]     r_cnt;
   logic              r_addr_err;
   logic              w_act, w_cli_we;
   logic [AW-1:0]     w_cli_waddr, w_cli_raddr0, w_cli_raddr1;
   logic [WORD_W-1:0] w_cli_wdata, w_rdata0, w_rdata1, w_wdata;
   logic              w_wr_ok, w_rd0_ok, w_rd1_ok, w_bad;
   logic              w_idle, w_clear, w_start, w_we;
   logic [IW-1:0]     w_waddr;

   always_comb begin
      w_act        = 1'b1;
      w_cli_we     = 1'b0;
      w_cli_waddr  = '0;
      w_cli_wdata  = '0;
      w_cli_raddr0 = '0;
      w_cli_raddr1 = '0;
      case (sel_e'(i_sel))
         SEL_HIST: begin
            w_cli_we = i_hist_we; w_cli_waddr = i_hist_waddr; w_cli_wdata = i_hist_wdata;
            w_cli_raddr0 = i_hist_raddr0; w_cli_raddr1 = i_hist_raddr1;
         end
         SEL_CDF: begin
            w_cli_we = i_cdf_we; w_cli_waddr = i_cdf_waddr; w_cli_wdata = i_cdf_wdata;
            w_cli_raddr0 = i_cdf_raddr0; w_cli_raddr1 = i_cdf_raddr1;
         end
         SEL_DIV: begin
            w_cli_we = i_div_we; w_cli_waddr = i_div_waddr; w_cli_wdata = i_div_wdata;
            w_cli_raddr0 = i_div_raddr0; w_cli_raddr1 = i_div_raddr1;
         end
         default: w_act = 1'b0;
      endcase
   end

   assign w_wr_ok  = w_act && w_cli_we && (w_cli_waddr < AW'(DEPTH));
   assign w_rd0_ok = w_act && (w_cli_raddr0 < AW'(DEPTH));
   assign w_rd1_ok = w_act && (w_cli_raddr1 < AW'(DEPTH));
   assign w_bad    = w_act && ((w_cli_we && !w_wr_ok) || !w_rd0_ok || !w_rd1_ok);

   assign w_idle  = (r_state == IDLE);
   assign w_clear = (r_state == CLEAR);
   assign w_start = w_idle && i_clear_req;

   // The sweep owns the write port; the edge entering CLEAR already loads zero read data.
   assign w_we    = w_clear || (w_idle && w_wr_ok);
   assign w_waddr = w_clear ? r_cnt : w_cli_waddr[IW-1:0];
   assign w_wdata = w_clear ? '0 : w_cli_wdata;

   scratch_mem_array #(.DEPTH(DEPTH), .IW(IW)) u_array (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_we     (w_we),
      .i_waddr  (w_waddr),
      .i_wdata  (w_wdata),
      .i_raddr0 (w_cli_raddr0[IW-1:0]),
      .i_raddr1 (w_cli_raddr1[IW-1:0]),
      .i_rzero0 (!w_idle || w_start || !w_rd0_ok),
      .i_rzero1 (!w_idle || w_start || !w_rd1_ok),
      .o_rdata0 (w_rdata0),
      .o_rdata1 (w_rdata1)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (i_clear_req) w_next = CLEAR;
         CLEAR:   if (r_cnt == IW'(DEPTH - 1)) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      o_busy       = (r_state == CLEAR);
      o_clear_done = (r_state == DONE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)     r_cnt <= '0;
      else if (w_start) r_cnt <= '0;
      else if (w_clear) r_cnt <= r_cnt + 1'b1;
   end

   // Only accesses that actually reach the array (selected client, IDLE) can raise the flag.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)              r_addr_err <= 1'b0;
      else if (w_start)          r_addr_err <= 1'b0;
      else if (w_idle && w_bad)  r_addr_err <= 1'b1;
   end

   assign o_addr_err    = r_addr_err;
   assign o_hist_rdata0 = w_rdata0;
   assign o_hist_rdata1 = w_rdata1;
   assign o_cdf_rdata0  = w_rdata0;
   assign o_cdf_rdata1  = w_rdata1;
   assign o_div_rdata0  = w_rdata0;
   assign o_div_rdata1  = w_rdata1;
endmodule

// File: tb/tb_scratch_mem_responder.sv
// Randomized bench for scratch_mem_responder against a cycle-level behavioural model.
module tb_scratch_mem_responder;
   localparam int DEPTH = 64;
   localparam int AW    = 16;
   localparam int W     = 128;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    sel;
   logic          clear_req;
   logic [AW-1:0] ra0 [3];
   logic [AW-1:0] ra1 [3];
   logic [AW-1:0] wa  [3];
   logic          we  [3];
   logic [W-1:0]  wd  [3];
   logic [W-1:0]  rd0 [3];
   logic [W-1:0]  rd1 [3];
   logic          busy, cdone, aerr;

   always #5 clk = ~clk;

   scratch_mem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_sel(sel), .i_clear_req(clear_req),
      .i_hist_raddr0(ra0[0]), .i_hist_raddr1(ra1[0]), .i_hist_we(we[0]),
      .i_hist_waddr(wa[0]), .i_hist_wdata(wd[0]),
      .i_cdf_raddr0(ra0[1]), .i_cdf_raddr1(ra1[1]), .i_cdf_we(we[1]),
      .i_cdf_waddr(wa[1]), .i_cdf_wdata(wd[1]),
      .i_div_raddr0(ra0[2]), .i_div_raddr1(ra1[2]), .i_div_we(we[2]),
      .i_div_waddr(wa[2]), .i_div_wdata(wd[2]),
      .o_hist_rdata0(rd0[0]), .o_hist_rdata1(rd1[0]),
      .o_cdf_rdata0(rd0[1]), .o_cdf_rdata1(rd1[1]),
      .o_div_rdata0(rd0[2]), .o_div_rdata1(rd1[2]),
      .o_busy(busy), .o_clear_done(cdone), .o_addr_err(aerr)
   );

   // Model: mode 0 = idle, 1 = sweeping (ccnt words done), 2 = done pulse.
   logic [W-1:0] mem [DEPTH];
   int           mode = 0;
   int           ccnt = 0;
   logic         err  = 1'b0;
   logic [W-1:0] e0 = '0, e1 = '0;
   int           n_vec = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] rd_mem(input logic [AW-1:0] a);
      if (int'(a) < DEPTH) return mem[int'(a)];
      err = 1'b1;
      return '0;
   endfunction

   function automatic void model_edge();
      int c;
      if (mode == 1) begin
         mem[ccnt] = '0;
         ccnt++;
         if (ccnt == DEPTH) mode = 2;
         e0 = '0; e1 = '0;
      end else if (mode == 2) begin
         mode = 0;
         e0 = '0; e1 = '0;
      end else begin
         e0 = '0; e1 = '0;
         if (sel != 2'd3) begin
            c = int'(sel);
            if (we[c]) begin
               if (int'(wa[c]) < DEPTH) mem[int'(wa[c])] = wd[c];
               else err = 1'b1;
            end
            e0 = rd_mem(ra0[c]);
            e1 = rd_mem(ra1[c]);
         end
         if (clear_req) begin
            mode = 1; ccnt = 0; err = 1'b0; e0 = '0; e1 = '0;
         end
      end
   endfunction

   task automatic check_outs();
      chk("busy", W'(busy), W'(mode == 1));
      chk("clear_done", W'(cdone), W'(mode == 2));
      chk("addr_err", W'(aerr), W'(err));
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rdata0[%0d]", i), rd0[i], e0);
         chk($sformatf("rdata1[%0d]", i), rd1[i], e1);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      check_outs();
   endtask

   task automatic idle_in();
      sel = 2'd3; clear_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ra0[i] = '0; ra1[i] = '0; wa[i] = '0; we[i] = 1'b0; wd[i] = '0;
      end
   endtask

   // Full sweep; optionally pulses clear_req again mid-sweep, which must be ignored.
   task automatic sweep(input int extra_at);
      int nb, nd;
      nb = 0; nd = 0;
      clear_req = 1'b1;
      cycle();
      clear_req = 1'b0;
      for (int i = 0; i < 68; i++) begin
         if (busy) nb++;
         if (cdone) nd++;
         clear_req = (i == extra_at);
         cycle();
      end
      clear_req = 1'b0;
      chk("busy_cycles", W'(nb), W'(64));
      chk("done_pulses", W'(nd), W'(1));
   endtask

   function automatic logic [W-1:0] rnd_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W-1:0] wa33, a34, y35;
      idle_in();
      rst_n = 1'b0;
      @(negedge clk); @(negedge clk);
      check_outs();
      rst_n = 1'b1;

      // Zero-fill, then every word reads back 0 on both ports.
      sweep(-1);
      sel = 2'd0;
      for (int a = 0; a < DEPTH; a++) begin
         ra0[0] = AW'(a); ra1[0] = AW'(DEPTH - 1 - a);
         cycle();
      end

      // Plain write then read.
      wa33 = 128'h0000_0000_0000_0000_0001_0002_0003_0004;
      we[0] = 1'b1; wa[0] = 16'd5; wd[0] = wa33; ra0[0] = 16'd9;
      cycle();
      we[0] = 1'b0; ra0[0] = 16'd5;
      cycle();
      chk("hist_rd_addr5", rd0[0], wa33);

      // Same-cycle write/read bypass.
      a34 = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
      we[0] = 1'b1; wa[0] = 16'd7; wd[0] = a34; ra0[0] = 16'd7;
      cycle();
      chk("bypass_addr7", rd0[0], a34);
      we[0] = 1'b0;

      // Unselected client write dropped, selected client write stored.
      sel = 2'd1;
      we[0] = 1'b1; wa[0] = 16'd3; wd[0] = rnd_word();
      cycle();
      we[0] = 1'b0; ra0[1] = 16'd3;
      cycle();
      chk("unsel_write_dropped", rd0[1], '0);
      y35 = rnd_word();
      we[1] = 1'b1; wa[1] = 16'd3; wd[1] = y35;
      cycle();
      we[1] = 1'b0;
      cycle();
      chk("cdf_write_stored", rd0[1], y35);

      // Out-of-range read: zero data, sticky flag, cleared by next clear_req.
      sel = 2'd2; ra1[2] = 16'd64;
      cycle();
      chk("oor_rdata1", rd1[2], '0);
      chk("oor_addr_err", W'(aerr), W'(1));
      ra1[2] = 16'd0;
      repeat (3) cycle();
      chk("addr_err_sticky", W'(aerr), W'(1));
      sweep(30);
      chk("addr_err_cleared", W'(aerr), W'(0));

      // Reset in the middle of a sweep aborts it without a done pulse.
      clear_req = 1'b1;
      cycle();
      clear_req = 1'b0;
      for (int i = 0; i < 9; i++) begin
         clear_req = (i == 4);
         cycle();
      end
      clear_req = 1'b0;
      rst_n = 1'b0;
      #1;
      mode = 0; err = 1'b0; e0 = '0; e1 = '0;
      chk("abort_busy_low", W'(busy), W'(0));
      chk("abort_no_done", W'(cdone), W'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (70) cycle();
      sweep(-1);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         sel = 2'($urandom_range(0, 3));
         clear_req = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < 3; i++) begin
            we[i]  = $urandom_range(0, 1) == 1;
            wa[i]  = ($urandom_range(0, 79) == 0) ? AW'($urandom_range(DEPTH, DEPTH + 8)) : AW'($urandom_range(0, 15));
            wd[i]  = rnd_word();
            ra0[i] = ($urandom_range(0, 3) == 0) ? wa[i] : AW'($urandom_range(0, 15));
            ra1[i] = ($urandom_range(0, 79) == 0) ? AW'($urandom_range(DEPTH, 65535)) : AW'($urandom_range(0, DEPTH - 1));
         end
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/scratch_mem_responder.md
SCRATCH_MEM_RESPONDER -- requirements
Module: scratch_mem_responder

Interface
REQ-001 Parameter DEPTH, default 64, number of 128-bit words (256 bins x 32 bit / 4 bins per word).
REQ-002 Parameter AW, default 16, width of every address port.
REQ-003 clock  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (reset=0 asserts).
REQ-005 sel  in  2  client select: 0 histogram, 1 cdf, 2 divider, 3 none.
REQ-006 clear_req  in  1  single-cycle pulse requesting a zero-fill of all DEPTH words.
REQ-007 {hist,cdf,div}_raddr0 / _raddr1  in  AW each  per-client read addresses.
REQ-008 {hist,cdf,div}_WE  in  1 each; {hist,cdf,div}_waddr  in  AW each; {hist,cdf,div}_wdata  in  128 each.
REQ-009 {hist,cdf,div}_rdata0 / _rdata1  out  128 each  per-client read data.
REQ-010 busy  out  1  high while the zero-fill runs.
REQ-011 clear_done  out  1  single-cycle pulse when the zero-fill finishes.
REQ-012 addr_err  out  1  sticky out-of-range access flag.

Function
REQ-013 Only the client selected by sel reaches the array; WE of unselected clients SHALL be ignored; sel=3 issues no write.
REQ-014 Reads SHALL be synchronous, latency 1: address sampled at edge N, data valid after edge N, held until the next edge.
REQ-015 Read data SHALL be driven to all three clients' rdata ports identically.
REQ-016 If the selected WE=1 and waddr equals a raddr in the same cycle, that port SHALL return the new wdata (write-first bypass), as required by histogram read-modify-write.
REQ-017 Both read ports SHALL be independent; equal raddr0/raddr1 return identical data.
REQ-018 Read address >= DEPTH SHALL return 0 and set addr_err; write address >= DEPTH SHALL be dropped and set addr_err.
REQ-019 addr_err SHALL stay set until reset or the next clear_req.
REQ-020 FSM states: IDLE, CLEAR, DONE.
REQ-021 IDLE -> CLEAR on clear_req; clear counter loads 0; busy=1 from the next cycle.
REQ-022 In CLEAR, one word per cycle SHALL be written to zero at the counter address; the counter increments; client writes are ignored and rdata reads 0.
REQ-023 CLEAR -> DONE after word DEPTH-1 is written (DEPTH cycles in CLEAR); DONE asserts clear_done for 1 cycle, then -> IDLE with busy=0.
REQ-024 clear_req while busy SHALL be ignored (no restart, no extension).
REQ-025 Zero-fill only affects the array; rdata registers are zero for the whole of CLEAR and DONE.
REQ-026 A sel change takes effect on the same edge; read data in flight belongs to the address sampled and is not recomputed.

Reset
REQ-027 On reset assertion: FSM -> IDLE, counter=0, busy=0, clear_done=0, addr_err=0, all rdata outputs=0.
REQ-028 Array contents are not reset; software issues clear_req after reset.
REQ-029 Reset during CLEAR SHALL abort the sweep immediately; no clear_done pulse is produced.

Structure
REQ-030 Shared package holds the client-select encodings (SEL_HIST, SEL_CDF, SEL_DIV, SEL_NONE), the FSM state encoding, and WORD_W=128.
REQ-031 The storage is a separate sub-module scratch_mem_array (1 write port, 2 synchronous read ports, write-first bypass); this block holds the mux, FSM and error logic.

Verification
REQ-032 Reset, clear_req -> busy high for 64 cycles, clear_done pulses once at cycle 65; all 64 words read back 0.
REQ-033 sel=0, hist write addr 5 = 0x...0001_0002_0003_0004, read addr 5 next cycle -> rdata0 equals the written word after 1 cycle.
REQ-034 sel=0, WE=1 waddr=7 wdata=A with raddr0=7 same cycle -> rdata0=A on the next cycle (bypass).
REQ-035 sel=1, hist_WE=1 to addr 3 -> addr 3 unchanged; cdf write to addr 3 -> stored.
REQ-036 sel=2, div_raddr1=64 -> rdata1=0, addr_err=1 and stays 1; next clear_req clears it.
REQ-037 clear_req, reset asserted at CLEAR cycle 10 -> busy=0 immediately, no clear_done; second clear_req mid-sweep ignored.
